// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port 12-bit frame-buffer RAM between the
// scan-out read path, a posted pixel-write client and an optional frame clear.
// Slot priority per cycle: READ > WRITE (FIFO drain) > CLEAR > IDLE.
// Optional feature macro: VRAM_CLEAR_EN (adds clear_start/clear_color/clear_busy).
module vram_arbiter #(
    parameter int unsigned WIDTH       = 640,
    parameter int unsigned HEIGHT      = 480,
    parameter int unsigned ADDR_W      = 19,
    parameter int unsigned WFIFO_DEPTH = 4
) (
    input  logic                                   CLK100MHZ,
    input  logic                                   reset,
    input  logic                                   pix_tick,
    input  logic [9:0]                             horizontal,
    input  logic [8:0]                             vertical,
    output logic [11:0]                            data,
    input  logic                                   wr_valid,
    output logic                                   wr_ready,
    input  logic [9:0]                             wr_x,
    input  logic [8:0]                             wr_y,
    input  logic [11:0]                            wr_color,
`ifdef VRAM_CLEAR_EN
    input  logic                                   clear_start,
    input  logic [11:0]                            clear_color,
    output logic                                   clear_busy,
`endif
    output logic                                   mem_en,
    output logic                                   mem_we,
    output logic [ADDR_W-1:0]                      mem_addr,
    output logic [11:0]                            mem_wdata,
    input  logic [11:0]                            mem_rdata,
    output logic [$clog2(WFIFO_DEPTH+1)-1:0]       fifo_level
);

    localparam int unsigned PTR_W   = $clog2(WFIFO_DEPTH);
    localparam int unsigned LVL_W   = $clog2(WFIFO_DEPTH+1);
    localparam int unsigned COLOR_W = 12;

    typedef struct packed {
        logic [ADDR_W-1:0]  addr;
        logic [COLOR_W-1:0] color;
    } wr_entry_t;

    // Write FIFO storage and bookkeeping
    wr_entry_t          fifo_q [WFIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]   level_q, level_d;
    logic               wr_ready_q;

    // Read pipeline: stage 1 = RAM access cycle, stage 2 = RAM data cycle
    logic               rd1_q, rd1_hit_q, rd2_q, rd2_hit_q;
    logic [COLOR_W-1:0] data_q;

    // Registered RAM interface
    logic               mem_en_q, mem_en_d, mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [COLOR_W-1:0] mem_wdata_q, mem_wdata_d;

    logic               rd_in_c, wr_in_c, rd_slot_c, push_c, pop_c;
    logic               fifo_full_c, fifo_empty_c, clr_slot_c;
    logic [ADDR_W-1:0]  rd_addr_c, wr_addr_c, clr_addr_c;
    logic [COLOR_W-1:0] clr_color_c;

    // Coordinate range checks and linear addresses
    assign rd_in_c   = (32'(horizontal) < WIDTH) && (32'(vertical) < HEIGHT);
    assign wr_in_c   = (32'(wr_x) < WIDTH) && (32'(wr_y) < HEIGHT);
    assign rd_addr_c = ADDR_W'(vertical) * ADDR_W'(WIDTH) + ADDR_W'(horizontal);
    assign wr_addr_c = ADDR_W'(wr_y) * ADDR_W'(WIDTH) + ADDR_W'(wr_x);

    // Slot decision; out-of-range ticks release the slot to lower priorities
    assign fifo_full_c  = (level_q == LVL_W'(WFIFO_DEPTH));
    assign fifo_empty_c = (level_q == '0);
    assign rd_slot_c    = pix_tick && rd_in_c;
    assign pop_c        = !rd_slot_c && !fifo_empty_c;
    assign push_c       = wr_valid && !fifo_full_c && wr_in_c;

`ifdef VRAM_CLEAR_EN
    localparam int unsigned PIXELS = WIDTH * HEIGHT;

    logic               clr_busy_q;
    logic [ADDR_W-1:0]  clr_addr_q;
    logic [COLOR_W-1:0] clr_color_q;

    assign clr_slot_c  = clr_busy_q && !rd_slot_c && fifo_empty_c;
    assign clr_addr_c  = clr_addr_q;
    assign clr_color_c = clr_color_q;
    assign clear_busy  = clr_busy_q;

    // Clear engine: walk every pixel address once, only in otherwise-free slots
    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            clr_busy_q  <= 1'b0;
            clr_addr_q  <= '0;
            clr_color_q <= '0;
        end else if (!clr_busy_q && clear_start) begin
            clr_busy_q  <= 1'b1;
            clr_addr_q  <= '0;
            clr_color_q <= clear_color;
        end else if (clr_slot_c) begin
            clr_addr_q <= clr_addr_q + ADDR_W'(1);
            if (clr_addr_q == ADDR_W'(PIXELS - 1)) begin
                clr_busy_q <= 1'b0;
            end
        end
    end
`else
    assign clr_slot_c  = 1'b0;
    assign clr_addr_c  = '0;
    assign clr_color_c = '0;
`endif

    // Next FIFO occupancy
    always_comb begin
        level_d = level_q;
        if (push_c && !pop_c) begin
            level_d = level_q + LVL_W'(1);
        end else if (!push_c && pop_c) begin
            level_d = level_q - LVL_W'(1);
        end
    end

    // Next RAM command from the winning slot; address/data hold when idle
    always_comb begin
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (rd_slot_c) begin
            mem_en_d   = 1'b1;
            mem_addr_d = rd_addr_c;
        end else if (pop_c) begin
            mem_en_d    = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = fifo_q[rd_ptr_q].addr;
            mem_wdata_d = fifo_q[rd_ptr_q].color;
        end else if (clr_slot_c) begin
            mem_en_d    = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = clr_addr_c;
            mem_wdata_d = clr_color_c;
        end
    end

    // FIFO payload storage (no reset needed; validity tracked by level_q)
    always_ff @(posedge CLK100MHZ) begin
        if (push_c) begin
            fifo_q[wr_ptr_q] <= '{addr: wr_addr_c, color: wr_color};
        end
    end

    // Control state: FIFO pointers, RAM command, read pipeline and pixel output
    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            wr_ready_q  <= 1'b1;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rd1_q       <= 1'b0;
            rd1_hit_q   <= 1'b0;
            rd2_q       <= 1'b0;
            rd2_hit_q   <= 1'b0;
            data_q      <= '0;
        end else begin
            if (push_c) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            level_q     <= level_d;
            wr_ready_q  <= (level_d != LVL_W'(WFIFO_DEPTH));
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rd1_q       <= pix_tick;
            rd1_hit_q   <= rd_in_c;
            rd2_q       <= rd1_q;
            rd2_hit_q   <= rd1_hit_q;
            if (rd2_q) begin
                data_q <= rd2_hit_q ? mem_rdata : '0;
            end
        end
    end

    assign data       = data_q;
    assign wr_ready   = wr_ready_q;
    assign mem_en     = mem_en_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign fifo_level = level_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: randomized + directed bench for vram_arbiter against a
// queue-based reference model of slot priority, write posting and read latency.
module tb_vram_arbiter;

    localparam int unsigned W     = 640;
    localparam int unsigned H     = 480;
    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        pix_tick;
    logic [9:0]  horizontal;
    logic [8:0]  vertical;
    logic [11:0] data;
    logic        wr_valid;
    logic        wr_ready;
    logic [9:0]  wr_x;
    logic [8:0]  wr_y;
    logic [11:0] wr_color;
    logic        mem_en;
    logic        mem_we;
    logic [18:0] mem_addr;
    logic [11:0] mem_wdata;
    logic [11:0] mem_rdata;
    logic [2:0]  fifo_level;
`ifdef VRAM_CLEAR_EN
    logic        clear_start = 1'b0;
    logic [11:0] clear_color = 12'h000;
    logic        clear_busy;
`endif

    vram_arbiter dut (
        .CLK100MHZ  (clk),
        .reset      (rst),
        .pix_tick   (pix_tick),
        .horizontal (horizontal),
        .vertical   (vertical),
        .data       (data),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_x       (wr_x),
        .wr_y       (wr_y),
        .wr_color   (wr_color),
`ifdef VRAM_CLEAR_EN
        .clear_start(clear_start),
        .clear_color(clear_color),
        .clear_busy (clear_busy),
`endif
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    // Power-on contents shared by the physical RAM and the reference memory
    function automatic logic [11:0] init_val(input int unsigned a);
        return 12'(a * 37) ^ 12'hF00;
    endfunction

    // Physical single-port RAM driven by the DUT
    logic [11:0] phys_mem [int unsigned];
    initial mem_rdata = 12'h000;
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                phys_mem[32'(mem_addr)] = mem_wdata;
            end else begin
                mem_rdata <= phys_mem.exists(32'(mem_addr)) ? phys_mem[32'(mem_addr)]
                                                            : init_val(32'(mem_addr));
            end
        end
    end

    // Reference model state
    typedef struct { int unsigned addr; logic [11:0] color; } wr_t;
    typedef struct { int due; logic [11:0] val; } rd_t;
    logic [11:0]  gold_mem [int unsigned];
    wr_t          wq[$];
    rd_t          pend[$];
    logic         exp_en, exp_we;
    int unsigned  exp_addr;
    logic [11:0]  exp_wdata, exp_data;
    int           cyc, n_err, n_chk;

    function automatic logic [11:0] gold_rd(input int unsigned a);
        return gold_mem.exists(a) ? gold_mem[a] : init_val(a);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Compare every observable output with the model's expectation for this cycle
    task automatic check_outputs();
        rd_t r;
        while (pend.size() > 0 && pend[0].due <= cyc) begin
            r = pend.pop_front();
            exp_data = r.val;
        end
        check("data", 32'(data), 32'(exp_data));
        check("mem_en", 32'(mem_en), 32'(exp_en));
        if (exp_en) begin
            check("mem_we", 32'(mem_we), 32'(exp_we));
            check("mem_addr", 32'(mem_addr), exp_addr);
            if (exp_we) check("mem_wdata", 32'(mem_wdata), 32'(exp_wdata));
        end
        check("wr_ready", 32'(wr_ready), 32'(wq.size() < DEPTH));
        check("fifo_level", 32'(fifo_level), 32'(wq.size()));
    endtask

    // One clock cycle: check outputs, drive inputs, advance the reference model
    task automatic step(input logic tk, input int h, input int v,
                        input logic wv, input int x, input int y, input logic [11:0] c);
        logic rd_ok, ready;
        wr_t  e;
        @(negedge clk);
        cyc++;
        check_outputs();
        pix_tick   = tk;
        horizontal = 10'(h);
        vertical   = 9'(v);
        wr_valid   = wv;
        wr_x       = 10'(x);
        wr_y       = 9'(y);
        wr_color   = c;
        rd_ok = tk && (h < W) && (v < H);
        ready = (wq.size() < DEPTH);
        if (tk) pend.push_back('{cyc + 3, rd_ok ? gold_rd(v * W + h) : 12'h000});
        exp_en = 1'b0;
        exp_we = 1'b0;
        if (rd_ok) begin
            exp_en   = 1'b1;
            exp_addr = v * W + h;
        end else if (wq.size() > 0) begin
            e = wq.pop_front();
            gold_mem[e.addr] = e.color;
            exp_en    = 1'b1;
            exp_we    = 1'b1;
            exp_addr  = e.addr;
            exp_wdata = e.color;
        end
        if (wv && ready && (x < W) && (y < H)) wq.push_back('{y * W + x, c});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 0, 1'b0, 0, 0, 12'h000);
    endtask

    initial begin
        n_err = 0; n_chk = 0; cyc = 0;
        exp_en = 1'b0; exp_we = 1'b0; exp_addr = 0; exp_wdata = 12'h000; exp_data = 12'h000;
        rst = 1'b1;
        pix_tick = 1'b0; horizontal = '0; vertical = '0;
        wr_valid = 1'b0; wr_x = '0; wr_y = '0; wr_color = '0;
        #3;
        check("rst_data", 32'(data), 32'h0);
        check("rst_wr_ready", 32'(wr_ready), 32'h1);
        check("rst_mem_en", 32'(mem_en), 32'h0);
        check("rst_mem_we", 32'(mem_we), 32'h0);
        check("rst_mem_addr", 32'(mem_addr), 32'h0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'h0);
        check("rst_fifo_level", 32'(fifo_level), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Reads at the corners and just outside the frame
        step(1'b1, 0, 0, 1'b0, 0, 0, 12'h000);
        idle(4);
        check("pix00_data", 32'(data), 32'hF00);
        step(1'b1, 639, 479, 1'b0, 0, 0, 12'h000);
        idle(3);
        step(1'b1, 640, 0, 1'b0, 0, 0, 12'h000);
        idle(4);

        // Fill the FIFO behind back-to-back reads, then let it drain
        for (int i = 0; i < 5; i++) step(1'b1, 10, 10, 1'b1, i, 1, 12'(12'h100 + i));
        idle(7);

        // Write colliding with a read: read first, write lands next, then read it back
        step(1'b1, 100, 100, 1'b1, 5, 2, 12'h0F0);
        idle(2);
        step(1'b1, 5, 2, 1'b0, 0, 0, 12'h000);
        idle(4);
        check("pix52_data", 32'(data), 32'h0F0);

        // Out-of-range write is accepted but never queued
        step(1'b0, 0, 0, 1'b1, 700, 10, 12'hABC);
        idle(3);

        // Randomized traffic, concentrated on a small patch so reads hit writes
        for (int i = 0; i < 3000; i++) begin
            logic tk, wv;
            int h, v, x, y;
            tk = ($urandom_range(0, 2) == 0);
            wv = ($urandom_range(0, 1) == 0);
            if ($urandom_range(0, 9) == 0) begin
                h = $urandom_range(0, 1023); v = $urandom_range(0, 511);
                x = $urandom_range(0, 1023); y = $urandom_range(0, 511);
            end else begin
                h = $urandom_range(0, 15); v = $urandom_range(0, 3);
                x = $urandom_range(0, 15); y = $urandom_range(0, 3);
            end
            step(tk, h, v, wv, x, y, 12'($urandom));
        end
        idle(8);

        // Reset in the middle of queued writes and an in-flight read
        step(1'b1, 1, 1, 1'b1, 20, 5, 12'h111);
        step(1'b1, 2, 1, 1'b1, 21, 5, 12'h222);
        step(1'b1, 3, 1, 1'b1, 22, 5, 12'h333);
        @(negedge clk);
        cyc++;
        check_outputs();
        pix_tick = 1'b0; wr_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("mid_rst_data", 32'(data), 32'h0);
        check("mid_rst_mem_en", 32'(mem_en), 32'h0);
        check("mid_rst_mem_addr", 32'(mem_addr), 32'h0);
        check("mid_rst_wr_ready", 32'(wr_ready), 32'h1);
        check("mid_rst_fifo_level", 32'(fifo_level), 32'h0);
        wq.delete();
        pend.delete();
        exp_data = 12'h000; exp_en = 1'b0; exp_we = 1'b0;
        @(negedge clk);
        cyc++;
        rst = 1'b0;
        idle(2);
        step(1'b1, 20, 5, 1'b0, 0, 0, 12'h000);
        idle(4);
        check("lost_write_data", 32'(data), 32'(init_val(5 * W + 20)));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
